counter_poll: RTL and testbench

- Requester side of the counter read-out interface.
- On a `start` pulse, it walks `idx` across all counter slots, issuing `req` for each and waiting for the responder's `valid`/`data`.
- It captures each returned count into a snapshot register bank, flags slots that time out, and reports the sum of all captured counts.
- It sits between the transaction-layer control logic and the counter mux, so the counter mux no longer has to be driven by the bench.

---
 rtl/counter_pkg.sv | 28 ++
 rtl/poll_timeout.sv | 44 ++++
 rtl/counter_poll.sv | 179 +++++++++++++++++
 tb/tb_counter_poll.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the counter read-out interface.
//   - Default geometry of the counter bank (slot count, data and idx widths).
//   - Default requester timeout.
//   - Poll FSM state encoding.
//   - idx encoding shared with the counter mux: plain binary slot number,
//     starting at IDX_FIRST and stepping by one per slot.
// Ports: none (package).
// -----------------------------------------------------------------------------
package counter_pkg;

    localparam int NUM_COUNTERS_DEF = 5;
    localparam int DATA_WIDTH_DEF   = 8;
    localparam int IDX_WIDTH_DEF    = 3;
    localparam int TIMEOUT_DEF      = 15;

    // First slot index of a sweep; the counter mux decodes idx as binary.
    localparam logic [IDX_WIDTH_DEF-1:0] IDX_FIRST = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } poll_state_t;

endpackage

// File: rtl/poll_timeout.sv
// -----------------------------------------------------------------------------
// poll_timeout
// Loadable saturating down-counter used to bound how long a requester waits
// for an answer. Load it with (limit-1) when the request starts; every cycle
// without an answer, pulse i_enable. o_expired is high once the count has
// reached zero, i.e. on the limit-th waiting cycle.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-low reset (count -> 0)
//   i_load     in   load i_load_val into the counter
//   i_load_val in   value to load
//   i_clear    in   force the counter to zero (highest priority after reset)
//   i_enable   in   decrement by one, holding at zero
//   o_expired  out  counter is zero
// -----------------------------------------------------------------------------
module poll_timeout #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/counter_poll.sv
// -----------------------------------------------------------------------------
// counter_poll
// Requester side of the counter read-out interface. A start pulse launches a
// sweep over all counter slots: for each slot idx is driven, req is raised,
// and the requester waits for valid/data. Each answer is captured into a
// snapshot bank and added to a running total; a slot that does not answer
// within TIMEOUT cycles is recorded as 0 and flagged in err. done pulses for
// one cycle when the sweep ends.
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous active-low reset; aborts a sweep without done
//   start   in   one-cycle sweep request, honoured only in IDLE
//   data    in   count returned by the responder
//   valid   in   data is valid for the current idx (sampled only in REQ)
//   req     out  read request to the responder
//   idx     out  slot being requested
//   counts  out  snapshot bank, slot k at [k*DATA_WIDTH +: DATA_WIDTH]
//   err     out  bit k: slot k timed out during the last sweep
//   total   out  sum of captured counts of the last sweep (wraps for >8 slots)
//   busy    out  a sweep is in progress
//   done    out  one-cycle pulse at the end of a sweep
// -----------------------------------------------------------------------------
import counter_pkg::*;

module counter_poll #(
    parameter int NUM_COUNTERS = NUM_COUNTERS_DEF,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int IDX_WIDTH    = IDX_WIDTH_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [DATA_WIDTH-1:0]              data,
    input  logic                               valid,
    output logic                               req,
    output logic [IDX_WIDTH-1:0]               idx,
    output logic [NUM_COUNTERS*DATA_WIDTH-1:0] counts,
    output logic [NUM_COUNTERS-1:0]            err,
    output logic [DATA_WIDTH+2:0]              total,
    output logic                               busy,
    output logic                               done
);

    localparam int TOTAL_WIDTH = DATA_WIDTH + 3;
    localparam int TO_WIDTH    = $clog2(TIMEOUT + 1);

    poll_state_t             r_state;
    logic                    r_req;
    logic [IDX_WIDTH-1:0]    r_idx;
    logic [DATA_WIDTH-1:0]   r_counts [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] r_err;
    logic [TOTAL_WIDTH-1:0]  r_total;
    logic                    r_busy;
    logic                    r_done;

    logic [NUM_COUNTERS-1:0] w_slot_sel;
    logic                    w_last_slot;
    logic                    w_to_load;
    logic                    w_to_clear;
    logic                    w_to_enable;
    logic                    w_expired;

    // One-hot decode of the slot currently requested, plus the output view of
    // the snapshot bank.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_COUNTERS; gi++) begin : g_slot
            assign w_slot_sel[gi] = (r_idx == IDX_WIDTH'(gi));
            assign counts[gi*DATA_WIDTH +: DATA_WIDTH] = r_counts[gi];
        end
    endgenerate

    assign w_last_slot = (r_idx == IDX_WIDTH'(NUM_COUNTERS - 1));

    // The wait counter is armed on every transition into REQ; loading
    // TIMEOUT-1 makes it expire on the TIMEOUT-th REQ cycle.
    assign w_to_load   = ((r_state == ST_IDLE) && start) ||
                         ((r_state == ST_GAP) && !w_last_slot);
    assign w_to_clear  = (r_state == ST_REQ) && valid;
    assign w_to_enable = (r_state == ST_REQ) && !valid;

    poll_timeout #(
        .WIDTH (TO_WIDTH)
    ) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_to_load),
        .i_load_val (TO_WIDTH'(TIMEOUT - 1)),
        .i_clear    (w_to_clear),
        .i_enable   (w_to_enable),
        .o_expired  (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_idx   <= IDX_WIDTH'(IDX_FIRST);
            r_err   <= '0;
            r_total <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int k = 0; k < NUM_COUNTERS; k++) begin
                r_counts[k] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                        r_idx   <= IDX_WIDTH'(IDX_FIRST);
                        r_busy  <= 1'b1;
                        r_err   <= '0;
                        r_total <= '0;
                    end
                end

                ST_REQ: begin
                    // valid wins over expiry when both land in the same cycle
                    if (valid) begin
                        for (int k = 0; k < NUM_COUNTERS; k++) begin
                            if (w_slot_sel[k]) begin
                                r_counts[k] <= data;
                            end
                        end
                        r_total <= r_total + TOTAL_WIDTH'(data);
                        r_req   <= 1'b0;
                        r_state <= ST_GAP;
                    end else if (w_expired) begin
                        for (int k = 0; k < NUM_COUNTERS; k++) begin
                            if (w_slot_sel[k]) begin
                                r_counts[k] <= '0;
                            end
                        end
                        r_err   <= r_err | w_slot_sel;
                        r_req   <= 1'b0;
                        r_state <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    if (!w_last_slot) begin
                        r_idx   <= r_idx + IDX_WIDTH'(1);
                        r_req   <= 1'b1;
                        r_state <= ST_REQ;
                    end else begin
                        r_idx   <= IDX_WIDTH'(IDX_FIRST);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end
                end

                ST_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign req   = r_req;
    assign idx   = r_idx;
    assign err   = r_err;
    assign total = r_total;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_counter_poll.sv
// -----------------------------------------------------------------------------
// tb_counter_poll
// Directed bench for counter_poll with the default geometry (5 slots, 8-bit
// data, 3-bit idx, timeout 15). A behavioural responder lives in step(): it
// answers slot k lat[k] cycles after req rises, or never when silent[k] is set.
// Step n of a sweep is the observation taken after the n-th rising edge
// following the cycle in which start was raised.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_counter_poll;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  data;
    logic        valid;
    logic        req;
    logic [2:0]  idx;
    logic [39:0] counts;
    logic [4:0]  err;
    logic [10:0] total;
    logic        busy;
    logic        done;

    counter_poll dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .data   (data),
        .valid  (valid),
        .req    (req),
        .idx    (idx),
        .counts (counts),
        .err    (err),
        .total  (total),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // responder configuration
    int         lat    [8];
    logic [7:0] dat    [8];
    bit         silent [8];
    bit         spur_gap;
    bit         spur_idle;
    bit         spur_start;
    int         rcnt;

    // sweep monitors
    int cyc;
    int done_cnt;
    int done_cyc;
    int req_hi [8];
    int gap_cnt;
    int low_run;
    int max_low;
    int seq_bad;
    int exp_next;
    bit prev_req;
    bit found;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (req) begin
            req_hi[idx]++;
            if (!prev_req) begin
                if (idx != 3'(exp_next)) seq_bad++;
                exp_next++;
            end
        end
        if (busy && !req) begin
            gap_cnt++;
            low_run++;
            if (low_run > max_low) max_low = low_run;
        end else begin
            low_run = 0;
        end
        prev_req = req;
        // responder drive for the next rising edge
        if (req) begin
            rcnt++;
            if (!silent[idx] && rcnt == lat[idx] + 1) begin
                valid = 1'b1;
                data  = dat[idx];
            end else begin
                valid = 1'b0;
                data  = 8'd0;
            end
        end else begin
            rcnt = 0;
            if ((spur_gap && busy) || spur_idle) begin
                valid = 1'b1;
                data  = 8'd99;
            end else begin
                valid = 1'b0;
                data  = 8'd0;
            end
        end
        if (spur_start) start = (cyc == 5 || cyc == 10);
    endtask

    task automatic start_sweep();
        cyc = 0; done_cnt = 0; done_cyc = -1; gap_cnt = 0; low_run = 0;
        max_low = 0; seq_bad = 0; exp_next = 0; prev_req = 1'b0; rcnt = 0;
        for (int i = 0; i < 8; i++) req_hi[i] = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != 0) break;
            step();
        end
    endtask

    task automatic set_resp(input int l0, input int l1, input int l2, input int l3, input int l4,
                            input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                            input logic [7:0] d3, input logic [7:0] d4);
        lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3; lat[4] = l4;
        dat[0] = d0; dat[1] = d1; dat[2] = d2; dat[3] = d3; dat[4] = d4;
        for (int i = 0; i < 8; i++) silent[i] = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " req"},    64'(req),    64'd0);
        chk({tag, " idx"},    64'(idx),    64'd0);
        chk({tag, " counts"}, 64'(counts), 64'd0);
        chk({tag, " err"},    64'(err),    64'd0);
        chk({tag, " total"},  64'(total),  64'd0);
        chk({tag, " busy"},   64'(busy),   64'd0);
        chk({tag, " done"},   64'(done),   64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; valid = 1'b0; data = 8'd0;
        spur_gap = 1'b0; spur_idle = 1'b0; spur_start = 1'b0;
        set_resp(1, 1, 1, 1, 1, 0, 0, 0, 0, 0);

        // reset state
        step(); step();
        chk_zero("reset");
        reset = 1'b1;
        step();

        // A: normal sweep, latency 1
        set_resp(1, 1, 1, 1, 1, 8'd3, 8'd7, 8'd0, 8'd255, 8'd12);
        start_sweep();
        chk("A busy step1", 64'(busy), 64'd1);
        chk("A req step1",  64'(req),  64'd1);
        chk("A idx step1",  64'(idx),  64'd0);
        wait_done(60);
        chk("A done step", 64'(done_cyc), 64'd16);
        chk("A busy in FIN", 64'(busy), 64'd0);
        chk("A idx in FIN",  64'(idx),  64'd0);
        start = 1'b1;       // sampled while in FIN: must be ignored
        step();
        start = 1'b0;
        step(); step();
        chk("A done once", 64'(done_cnt), 64'd1);
        chk("A FIN start ignored busy", 64'(busy), 64'd0);
        chk("A FIN start ignored req",  64'(req),  64'd0);
        chk("A counts", 64'(counts), 64'h0C_FF_00_07_03);
        chk("A total",  64'(total),  64'd277);
        chk("A err",    64'(err),    64'd0);
        chk("A req low run", 64'(max_low), 64'd1);
        chk("A gap cycles",  64'(gap_cnt), 64'd5);
        chk("A idx order",   64'(seq_bad), 64'd0);
        chk("A req rises",   64'(exp_next), 64'd5);

        // B: variable latency; the 14-cycle answer lands on the timeout cycle
        set_resp(1, 4, 2, 14, 1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
        start_sweep();
        wait_done(80);
        chk("B done step", 64'(done_cyc), 64'd33);
        chk("B counts", 64'(counts), 64'h05_04_03_02_01);
        chk("B total",  64'(total),  64'd15);
        chk("B err",    64'(err),    64'd0);
        chk("B slot3 req cycles", 64'(req_hi[3]), 64'd15);
        step(); step();

        // C: slot 2 never answers
        set_resp(1, 1, 1, 1, 1, 8'd10, 8'd10, 8'd10, 8'd10, 8'd10);
        silent[2] = 1'b1;
        start_sweep();
        wait_done(80);
        chk("C done step", 64'(done_cyc), 64'd29);
        chk("C slot2 req cycles", 64'(req_hi[2]), 64'd15);
        chk("C counts", 64'(counts), 64'h0A_0A_00_0A_0A);
        chk("C err",    64'(err),    64'h04);
        chk("C total",  64'(total),  64'd40);
        step();

        // D: back-to-back start one cycle after done
        set_resp(1, 1, 1, 1, 1, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9);
        start_sweep();
        chk("D err cleared",   64'(err),    64'd0);
        chk("D total cleared", 64'(total),  64'd0);
        chk("D counts held",   64'(counts), 64'h0A_0A_00_0A_0A);
        wait_done(60);
        chk("D done step", 64'(done_cyc), 64'd16);
        chk("D counts", 64'(counts), 64'h09_08_07_06_05);
        chk("D total",  64'(total),  64'd35);
        chk("D err",    64'(err),    64'd0);
        step(); step();

        // E: restart attempts mid-sweep and spurious valid in GAP / IDLE
        set_resp(1, 1, 1, 1, 1, 8'd3, 8'd7, 8'd0, 8'd255, 8'd12);
        spur_gap = 1'b1;
        spur_start = 1'b1;
        start_sweep();
        wait_done(60);
        spur_gap = 1'b0;
        spur_start = 1'b0;
        start = 1'b0;
        chk("E done step", 64'(done_cyc), 64'd16);
        chk("E idx order", 64'(seq_bad), 64'd0);
        chk("E req rises", 64'(exp_next), 64'd5);
        chk("E counts", 64'(counts), 64'h0C_FF_00_07_03);
        chk("E total",  64'(total),  64'd277);
        step(); step();
        spur_idle = 1'b1;
        step(); step(); step();
        spur_idle = 1'b0;
        step();
        chk("E idle counts", 64'(counts), 64'h0C_FF_00_07_03);
        chk("E idle total",  64'(total),  64'd277);
        chk("E idle busy",   64'(busy),   64'd0);

        // F: reset while requesting slot 3
        start_sweep();
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (req && idx == 3'd3) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("F reached slot3", 64'(found), 64'd1);
        reset = 1'b0;
        step();
        chk_zero("F after reset");
        reset = 1'b1;
        repeat (25) step();
        chk("F no done", 64'(done_cnt), 64'd0);

        // G: full sweep after the aborted one
        start_sweep();
        wait_done(60);
        chk("G done step", 64'(done_cyc), 64'd16);
        chk("G counts", 64'(counts), 64'h0C_FF_00_07_03);
        chk("G total",  64'(total),  64'd277);
        chk("G err",    64'(err),    64'd0);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
